// File: rtl/cmp_iter.sv
// cmp_iter: multi-cycle signed/unsigned magnitude comparator, one chunk per cycle starting at the MSB chunk
module cmp_iter #(
    parameter int DATA_WIDTH  = 64,
    parameter int CHUNK_WIDTH = 16
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_start,
    input  logic [DATA_WIDTH-1:0] in_numA,
    input  logic [DATA_WIDTH-1:0] in_numB,
    output logic                  out_busy,
    output logic                  out_done,
    output logic [DATA_WIDTH-1:0] out_Signed,
    output logic [DATA_WIDTH-1:0] out_Unsigned,
    output logic [4:0]            out_flag
);
    localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IW     = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [4:0]              flag_q, flag_d;
    logic [CHUNK_WIDTH-1:0]  ca, cb;
    logic                    accept, last, ult, slt;

    always_comb begin
        ca     = CHUNK_WIDTH'(a_q >> (idx_q * CHUNK_WIDTH));
        cb     = CHUNK_WIDTH'(b_q >> (idx_q * CHUNK_WIDTH));
        accept = in_start && state_q != BUSY;
        last   = ca != cb || idx_q == '0;
        ult    = ca < cb;
        // differing sign bits decide the signed order outright; otherwise it matches unsigned
        slt    = a_q[DATA_WIDTH-1] != b_q[DATA_WIDTH-1] ? a_q[DATA_WIDTH-1] : ult;
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        flag_d  = flag_q;
        if (accept) begin
            state_d = BUSY;
            idx_d   = IW'(NCHUNK - 1);
            a_d     = in_numA;
            b_d     = in_numB;
        end else if (state_q == BUSY) begin
            state_d = last ? DONE : BUSY;
            idx_d   = last ? idx_q : idx_q - 1'b1;
            flag_d  = last ? {ca == cb, slt, ult, !slt, !ult} : flag_q;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            flag_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            flag_q  <= flag_d;
        end
    end

    assign out_busy     = state_q == BUSY;
    assign out_done     = state_q == DONE;
    assign out_Signed   = {{(DATA_WIDTH-1){1'b0}}, flag_q[3]};
    assign out_Unsigned = {{(DATA_WIDTH-1){1'b0}}, flag_q[2]};
    assign out_flag     = flag_q;
endmodule

// File: tb/tb_cmp_iter.sv
// tb_cmp_iter: randomized scoreboard bench for cmp_iter, plus a single-chunk 32-bit instance
module tb_cmp_iter;
    logic        in_clk = 1'b0;
    logic        in_rst = 1'b1;
    logic        in_start = 1'b0;
    logic [63:0] in_numA = '0, in_numB = '0;
    logic        out_busy, out_done;
    logic [63:0] out_Signed, out_Unsigned;
    logic [4:0]  out_flag;

    logic        s2 = 1'b0;
    logic [31:0] a2 = '0, b2 = '0;
    logic        busy2, done2;
    logic [31:0] sg2, us2;
    logic [4:0]  fl2;

    typedef struct packed {logic [4:0] f; logic [2:0] k;} exp_t;
    exp_t q[$];
    exp_t me;
    int   total = 0, bad = 0, bcnt = 0;

    cmp_iter dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_start(in_start),
        .in_numA(in_numA), .in_numB(in_numB),
        .out_busy(out_busy), .out_done(out_done),
        .out_Signed(out_Signed), .out_Unsigned(out_Unsigned), .out_flag(out_flag)
    );

    cmp_iter #(.DATA_WIDTH(32), .CHUNK_WIDTH(32)) dut2 (
        .in_clk(in_clk), .in_rst(in_rst), .in_start(s2),
        .in_numA(a2), .in_numB(b2),
        .out_busy(busy2), .out_done(done2),
        .out_Signed(sg2), .out_Unsigned(us2), .out_flag(fl2)
    );

    always #5 in_clk = ~in_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // chunks examined = 4 minus the chunk holding the highest differing bit
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] x;
        int          top;
        logic        lts, ltu;
        x   = a ^ b;
        top = -1;
        for (int i = 0; i < 64; i++) if (x[i]) top = i;
        lts = $signed(a) < $signed(b);
        ltu = a < b;
        model.k = 3'(top < 0 ? 4 : 4 - top / 16);
        model.f = {a == b, lts, ltu, !lts, !ltu};
    endfunction

    task automatic issue(input logic [63:0] a, input logic [63:0] b);
        int n;
        n = 0;
        @(negedge in_clk);
        while (out_busy && n < 100) begin
            @(negedge in_clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL wait_idle: busy still %0b after %0d cycles", out_busy, n);
        end
        in_start = 1'b1;
        in_numA  = a;
        in_numB  = b;
        q.push_back(model(a, b));
        @(posedge in_clk);
        #1;
        in_start = 1'b0;
        in_numA  = {$urandom, $urandom};
        in_numB  = {$urandom, $urandom};
        if ($urandom_range(0, 2) == 0) begin
            @(negedge in_clk);
            if (out_busy) begin
                in_start = 1'b1;
                @(posedge in_clk);
                #1;
                in_start = 1'b0;
            end
        end
    endtask

    initial begin
        logic [63:0] a, b;
        int          n;
        repeat (2) @(posedge in_clk);
        #1 in_rst = 1'b0;
        @(negedge in_clk);
        chk("rst_busy", 64'(out_busy), 64'd0);
        chk("rst_done", 64'(out_done), 64'd0);
        chk("rst_flag", 64'(out_flag), 64'd0);
        chk("rst_signed", out_Signed, 64'd0);
        chk("rst_unsigned", out_Unsigned, 64'd0);

        fork
            forever begin
                @(negedge in_clk);
                if (in_rst) bcnt = 0;
                else begin
                    if (out_busy) bcnt++;
                    if (out_done) begin
                        if (q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_done: got done=1 expected no pulse");
                        end else begin
                            me = q.pop_front();
                            chk("flag", 64'(out_flag), 64'(me.f));
                            chk("signed", out_Signed, {63'd0, me.f[3]});
                            chk("unsigned", out_Unsigned, {63'd0, me.f[2]});
                            chk("busy_cycles", 64'(bcnt), 64'(me.k));
                        end
                        bcnt = 0;
                    end
                end
            end
        join_none

        issue(64'd5, 64'd5);
        issue(64'h8000_0000_0000_0000, 64'd1);
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(64'h10, 64'h0F);
        issue(64'h0, 64'h0);
        for (int i = 0; i < 60; i++) begin
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b = {$urandom, $urandom};
                1: b = a;
                2: b = a ^ (64'd1 << $urandom_range(0, 63));
                default: b = a ^ 64'h8000_0000_0000_0000;
            endcase
            issue(a, b);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge in_clk);
        end
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge in_clk);
            n++;
        end
        chk("drain", 64'(q.size()), 64'd0);

        // abort: second start ignored while busy, then reset mid-comparison
        issue(64'd1, 64'd2);
        @(negedge in_clk);
        in_start = 1'b1;
        in_numA  = 64'd9;
        in_numB  = 64'd0;
        @(posedge in_clk);
        #1 in_start = 1'b0;
        @(negedge in_clk);
        chk("busy_before_rst", 64'(out_busy), 64'd1);
        in_rst = 1'b1;
        q.delete();
        @(posedge in_clk);
        #1 in_rst = 1'b0;
        @(negedge in_clk);
        chk("abort_busy", 64'(out_busy), 64'd0);
        chk("abort_done", 64'(out_done), 64'd0);
        chk("abort_flag", 64'(out_flag), 64'd0);
        chk("abort_signed", out_Signed, 64'd0);
        chk("abort_unsigned", out_Unsigned, 64'd0);
        repeat (8) @(negedge in_clk);
        chk("abort_idle", 64'(out_busy), 64'd0);

        // single-chunk instance: one busy cycle, done on the second edge
        for (int t = 0; t < 2; t++) begin
            @(negedge in_clk);
            s2 = 1'b1;
            a2 = t == 0 ? 32'h7FFF_FFFF : 32'h8000_0000;
            b2 = t == 0 ? 32'h8000_0000 : 32'h7FFF_FFFF;
            @(posedge in_clk);
            #1 s2 = 1'b0;
            a2 = $urandom;
            b2 = $urandom;
            @(negedge in_clk);
            chk("w32_busy", 64'(busy2), 64'd1);
            @(negedge in_clk);
            chk("w32_done", 64'(done2), 64'd1);
            chk("w32_flag", 64'(fl2), t == 0 ? 64'b00110 : 64'b01001);
            chk("w32_unsigned", 64'(us2), t == 0 ? 64'd1 : 64'd0);
            chk("w32_signed", 64'(sg2), t == 0 ? 64'd0 : 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cmp_iter.md
CMP_ITER -- requirements
Module: cmp_iter

Interface
REQ-001 Parameter DATA_WIDTH, default 64: operand width in bits.
REQ-002 Parameter CHUNK_WIDTH, default 16: bits compared per cycle; DATA_WIDTH SHALL be an integer multiple of CHUNK_WIDTH, and NCHUNK = DATA_WIDTH/CHUNK_WIDTH.
REQ-003 in_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 in_rst  input  1  synchronous, active-high reset.
REQ-005 in_start  input  1  request; accepted only on an edge where out_busy=0.
REQ-006 in_numA  input  DATA_WIDTH  operand A; sampled on the accept edge.
REQ-007 in_numB  input  DATA_WIDTH  operand B; sampled on the accept edge.
REQ-008 out_busy  output  1  high while a comparison is in progress.
REQ-009 out_done  output  1  one-cycle pulse; results valid.
REQ-010 out_Signed  output  DATA_WIDTH  1 if A<B as two's-complement, else 0; upper bits 0.
REQ-011 out_Unsigned  output  DATA_WIDTH  1 if A<B unsigned, else 0; upper bits 0.
REQ-012 out_flag  output  5  [4] equal, [3] signed less-than, [2] unsigned less-than, [1] signed greater-or-equal, [0] unsigned greater-or-equal.

Function
REQ-013 The FSM SHALL have states IDLE, BUSY, DONE; out_busy=1 only in BUSY; out_done=1 only in DONE.
REQ-014 IDLE or DONE with in_start=1: capture operands, load chunk index idx=NCHUNK-1, go to BUSY; DONE with in_start=0: go to IDLE; IDLE with in_start=0: stay.
REQ-015 Each BUSY cycle SHALL compare chunk idx (bits idx*CHUNK_WIDTH+CHUNK_WIDTH-1 down to idx*CHUNK_WIDTH) of the captured operands, MSB chunk first.
REQ-016 If the chunks differ, or idx=0, the FSM SHALL go to DONE on the next edge and register the results; otherwise decrement idx and stay in BUSY.
REQ-017 Latency: out_done SHALL rise k+1 edges after the accept edge, where k (1..NCHUNK) is the number of chunks examined; equal operands always take k=NCHUNK.
REQ-018 Unsigned less-than SHALL be decided by the first differing chunk (A chunk < B chunk); all chunks equal means not less and equal=1.
REQ-019 Signed less-than: if the sign bits (bit DATA_WIDTH-1) differ, A<B iff A is negative; otherwise equal to the unsigned result (true two's-complement ordering, not magnitude ordering).
REQ-020 out_flag[1] SHALL equal NOT out_flag[3], and out_flag[0] SHALL equal NOT out_flag[2] (equality implies both ge flags).
REQ-021 out_Signed, out_Unsigned, and out_flag SHALL be registered, SHALL update only on the edge entering DONE, and SHALL hold until the next result.
REQ-022 in_start while BUSY SHALL be ignored, with no effect on the operands or the result.
REQ-023 Operand inputs changing after the accept edge SHALL NOT affect the result.
REQ-024 CHUNK_WIDTH=DATA_WIDTH SHALL give a fixed 2-edge latency (one BUSY cycle).

Reset
REQ-025 in_rst=1 on an edge SHALL force the IDLE state and idx=0, and set out_busy=0, out_done=0, out_Signed=0, out_Unsigned=0, out_flag=5'b00000, and the captured operands to 0.
REQ-026 Reset SHALL take priority over in_start and SHALL abort an in-progress comparison; no out_done pulse follows.

Verification (DATA_WIDTH=64, CHUNK_WIDTH=16 unless noted)
REQ-027 A=5, B=5 -> 4 BUSY cycles, out_done on edge 5 after accept, out_flag=5'b10011, out_Signed=0, out_Unsigned=0.
REQ-028 A=0x8000_0000_0000_0000, B=1 -> 1 BUSY cycle, out_done on edge 2, out_flag=5'b01001, out_Signed=1, out_Unsigned=0.
REQ-029 A=0xFFFF_FFFF_FFFF_FFFF (-1), B=0xFFFF_FFFF_FFFF_FFFE (-2) -> 4 BUSY cycles, out_flag=5'b00011; a second test with the operands swapped -> out_flag=5'b01100.
REQ-030 Start A=1, B=2, pulse in_start (A=9, B=0) mid-BUSY, then assert in_rst during a later BUSY cycle -> the second start is ignored; after reset all outputs are 0, state is IDLE, and no out_done pulse occurs.
REQ-031 Assert in_start in the DONE cycle with A=0x10, B=0x0F -> out_busy=1 on the next edge, then results out_flag=5'b00011 with no IDLE gap.
REQ-032 DATA_WIDTH=32, CHUNK_WIDTH=32, A=0x7FFF_FFFF, B=0x8000_0000 -> out_done on edge 2, out_flag=5'b00110.
